// File: rtl/cpu_defs_pkg.sv
// Shared CPU encodings: opcodes, FSM states, PCSrc/RegDst/ALUOp codes.
// Reused by the controller, ALU and datapath blocks.
package cpu_defs;

  localparam int CPU_STATE_W = 3;
  localparam int CPU_OP_W    = 6;

  typedef enum logic [2:0] {
    S_IF   = 3'b000,
    S_ID   = 3'b001,
    S_EXE  = 3'b010,
    S_MEM  = 3'b011,
    S_WB   = 3'b100,
    S_HALT = 3'b111
  } state_t;

  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_SUB   = 6'b000001;
  localparam logic [5:0] OP_ADDIU = 6'b000010;
  localparam logic [5:0] OP_AND   = 6'b010000;
  localparam logic [5:0] OP_ANDI  = 6'b010001;
  localparam logic [5:0] OP_ORI   = 6'b010010;
  localparam logic [5:0] OP_SLL   = 6'b011000;
  localparam logic [5:0] OP_SLT   = 6'b100111;
  localparam logic [5:0] OP_SLTI  = 6'b100110;
  localparam logic [5:0] OP_SW    = 6'b110000;
  localparam logic [5:0] OP_LW    = 6'b110001;
  localparam logic [5:0] OP_BEQ   = 6'b110100;
  localparam logic [5:0] OP_BNE   = 6'b110101;
  localparam logic [5:0] OP_BLTZ  = 6'b110110;
  localparam logic [5:0] OP_J     = 6'b111000;
  localparam logic [5:0] OP_JR    = 6'b111001;
  localparam logic [5:0] OP_JAL   = 6'b111010;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  localparam logic [1:0] PC_NEXT   = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_RS     = 2'b10;
  localparam logic [1:0] PC_JUMP   = 2'b11;

  localparam logic [1:0] DST_RA = 2'b00;
  localparam logic [1:0] DST_RT = 2'b01;
  localparam logic [1:0] DST_RD = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_SLL = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_AND = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b110;
  localparam logic [2:0] ALU_XOR = 3'b111;

  // Branches reuse the ALU as a comparator, so they map onto sub / slt.
  function automatic logic [2:0] alu_op_for(input logic [5:0] op);
    logic [2:0] alu;
    alu = ALU_ADD;
    case (op)
      OP_SUB, OP_BEQ, OP_BNE:     alu = ALU_SUB;
      OP_AND, OP_ANDI:            alu = ALU_AND;
      OP_ORI:                     alu = ALU_OR;
      OP_SLL:                     alu = ALU_SLL;
      OP_SLT, OP_SLTI, OP_BLTZ:   alu = ALU_SLT;
      default:                    alu = ALU_ADD;
    endcase
    return alu;
  endfunction

endpackage

// File: rtl/perf_counter.sv
// Free-running cycle and retired-instruction counters, wrapping at 2^32.
module perf_counter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cycle_en,
  input  logic        instr_en,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instr_cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt <= 32'd0;
      instr_cnt <= 32'd0;
    end else begin
      if (cycle_en) cycle_cnt <= cycle_cnt + 32'd1;
      if (instr_en) instr_cnt <= instr_cnt + 32'd1;
    end
  end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle IF/ID/EXE/MEM/WB control unit driving all datapath strobes.
// Optional PERF_CNT_EN adds cycleCnt/instrCnt performance counters.
module multi_cycle_ctrl
  import cpu_defs::*;
#(
  parameter int STATE_W = CPU_STATE_W,
  parameter int OP_W    = CPU_OP_W
) (
  input  logic               CLK,
  input  logic               nReset,
  input  logic [OP_W-1:0]    opcode,
  input  logic               zero,
  input  logic               sign,
  output logic               PCWre,
  output logic [1:0]         PCSrc,
  output logic               IRWre,
  output logic               RegWre,
  output logic [1:0]         RegDst,
  output logic               WrRegDSrc,
  output logic               ALUSrcA,
  output logic               ALUSrcB,
  output logic [2:0]         ALUOp,
  output logic               ExtSel,
  output logic               mRD,
  output logic               mWR,
  output logic               DBDataSrc,
  output logic [STATE_W-1:0] State
`ifdef PERF_CNT_EN
  ,
  output logic [31:0]        cycleCnt,
  output logic [31:0]        instrCnt
`endif
);

  state_t state, state_next;

  logic is_rtype, is_imm, is_lw, is_sw, is_branch, taken;
  logic use_shamt, use_imm, sign_ext;
  logic [2:0] alu_op;

  assign is_rtype  = (opcode == OP_ADD) || (opcode == OP_SUB) || (opcode == OP_AND) ||
                     (opcode == OP_SLL) || (opcode == OP_SLT);
  assign is_imm    = (opcode == OP_ADDIU) || (opcode == OP_ANDI) || (opcode == OP_ORI) ||
                     (opcode == OP_SLTI);
  assign is_lw     = (opcode == OP_LW);
  assign is_sw     = (opcode == OP_SW);
  assign is_branch = (opcode == OP_BEQ) || (opcode == OP_BNE) || (opcode == OP_BLTZ);
  assign taken     = ((opcode == OP_BEQ) && zero) || ((opcode == OP_BNE) && !zero) ||
                     ((opcode == OP_BLTZ) && sign);
  assign use_shamt = (opcode == OP_SLL);
  assign use_imm   = is_imm || is_lw || is_sw;
  assign sign_ext  = (opcode == OP_ADDIU) || (opcode == OP_SLTI) || is_lw || is_sw || is_branch;
  assign alu_op    = alu_op_for(opcode);

  always_ff @(posedge CLK or negedge nReset) begin
    if (!nReset) state <= S_IF;
    else         state <= state_next;
  end

  // Operand selects are driven identically in EXE, MEM and WB to keep the datapath stable.
  always_comb begin
    state_next = state;
    PCWre      = 1'b0;
    PCSrc      = PC_NEXT;
    IRWre      = 1'b0;
    RegWre     = 1'b0;
    RegDst     = DST_RA;
    WrRegDSrc  = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 1'b0;
    ALUOp      = ALU_ADD;
    ExtSel     = 1'b0;
    mRD        = 1'b0;
    mWR        = 1'b0;
    DBDataSrc  = 1'b0;

    if (state == S_EXE || state == S_MEM || state == S_WB) begin
      ALUSrcA = use_shamt;
      ALUSrcB = use_imm;
      ALUOp   = alu_op;
      ExtSel  = sign_ext;
    end

    case (state)
      S_IF: begin
        IRWre      = 1'b1;
        state_next = S_ID;
      end
      S_ID: begin
        case (opcode)
          OP_J: begin
            PCWre      = 1'b1;
            PCSrc      = PC_JUMP;
            state_next = S_IF;
          end
          OP_JR: begin
            PCWre      = 1'b1;
            PCSrc      = PC_RS;
            state_next = S_IF;
          end
          OP_JAL: begin
            PCWre      = 1'b1;
            PCSrc      = PC_JUMP;
            RegWre     = 1'b1;
            RegDst     = DST_RA;
            WrRegDSrc  = 1'b0;
            state_next = S_IF;
          end
          OP_HALT: state_next = S_HALT;
          default: state_next = S_EXE;
        endcase
      end
      S_EXE: begin
        if (is_branch) begin
          PCWre      = 1'b1;
          PCSrc      = taken ? PC_BRANCH : PC_NEXT;
          state_next = S_IF;
        end else if (is_lw || is_sw) begin
          state_next = S_MEM;
        end else begin
          state_next = S_WB;
        end
      end
      S_MEM: begin
        if (is_lw) begin
          mRD        = 1'b1;
          state_next = S_WB;
        end else begin
          mWR        = is_sw;
          PCWre      = 1'b1;
          state_next = S_IF;
        end
      end
      S_WB: begin
        RegWre     = is_rtype || is_imm || is_lw;
        RegDst     = is_rtype ? DST_RD : (is_imm || is_lw) ? DST_RT : DST_RA;
        WrRegDSrc  = 1'b1;
        DBDataSrc  = is_lw;
        PCWre      = 1'b1;
        state_next = S_IF;
      end
      S_HALT:  state_next = S_HALT;
      default: state_next = S_IF;
    endcase
  end

  assign State = STATE_W'(state);

`ifdef PERF_CNT_EN
  perf_counter u_perf_counter (
    .clk       (CLK),
    .rst_n     (nReset),
    .cycle_en  (state != S_HALT),
    .instr_en  (PCWre),
    .cycle_cnt (cycleCnt),
    .instr_cnt (instrCnt)
  );
`endif

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Self-checking bench for multi_cycle_ctrl: directed plan plus random instruction stream.
module tb_multi_cycle_ctrl;

  localparam logic [5:0] B_ADD = 6'b000000, B_SUB = 6'b000001, B_ADDIU = 6'b000010;
  localparam logic [5:0] B_AND = 6'b010000, B_ANDI = 6'b010001, B_ORI = 6'b010010;
  localparam logic [5:0] B_SLL = 6'b011000, B_SLT = 6'b100111, B_SLTI = 6'b100110;
  localparam logic [5:0] B_SW = 6'b110000, B_LW = 6'b110001, B_BEQ = 6'b110100;
  localparam logic [5:0] B_BNE = 6'b110101, B_BLTZ = 6'b110110, B_J = 6'b111000;
  localparam logic [5:0] B_JR = 6'b111001, B_JAL = 6'b111010, B_HALT = 6'b111111;

  typedef enum {K_RTYPE, K_ITYPE, K_LW, K_SW, K_BR, K_J, K_JR, K_JAL, K_HALT, K_NOP} kind_t;

  logic       CLK, nReset, zero, sign;
  logic [5:0] opcode;
  logic       PCWre, IRWre, RegWre, WrRegDSrc, ALUSrcA, ALUSrcB, ExtSel, mRD, mWR, DBDataSrc;
  logic [1:0] PCSrc, RegDst;
  logic [2:0] ALUOp, State;
`ifdef PERF_CNT_EN
  logic [31:0] cycleCnt, instrCnt;
`endif

  int compared = 0;
  int mismatched = 0;

  multi_cycle_ctrl dut (
    .CLK(CLK), .nReset(nReset), .opcode(opcode), .zero(zero), .sign(sign),
    .PCWre(PCWre), .PCSrc(PCSrc), .IRWre(IRWre), .RegWre(RegWre), .RegDst(RegDst),
    .WrRegDSrc(WrRegDSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .ExtSel(ExtSel), .mRD(mRD), .mWR(mWR), .DBDataSrc(DBDataSrc), .State(State)
`ifdef PERF_CNT_EN
    , .cycleCnt(cycleCnt), .instrCnt(instrCnt)
`endif
  );

  logic [19:0] obs;
  assign obs = {PCWre, PCSrc, IRWre, RegWre, RegDst, WrRegDSrc, ALUSrcA, ALUSrcB,
                ALUOp, ExtSel, mRD, mWR, DBDataSrc, State};

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic kind_t kind_of(input logic [5:0] op);
    case (op)
      B_ADD, B_SUB, B_AND, B_SLL, B_SLT: return K_RTYPE;
      B_ADDIU, B_ANDI, B_ORI, B_SLTI:    return K_ITYPE;
      B_LW:                              return K_LW;
      B_SW:                              return K_SW;
      B_BEQ, B_BNE, B_BLTZ:              return K_BR;
      B_J:                               return K_J;
      B_JR:                              return K_JR;
      B_JAL:                             return K_JAL;
      B_HALT:                            return K_HALT;
      default:                           return K_NOP;
    endcase
  endfunction

  // Cycle count per instruction class; halt is observed for 20 cycles after ID.
  function automatic int n_phases(input kind_t k);
    case (k)
      K_LW:            return 5;
      K_BR:            return 3;
      K_J, K_JR, K_JAL: return 2;
      K_HALT:          return 22;
      default:         return 4;
    endcase
  endfunction

  function automatic logic [2:0] state_at(input kind_t k, input int p);
    if (k == K_HALT) return (p == 0) ? 3'd0 : (p == 1) ? 3'd1 : 3'd7;
    if (p < 3) return 3'(p);
    if (p == 3) return (k == K_LW || k == K_SW) ? 3'd3 : 3'd4;
    return 3'd4;
  endfunction

  function automatic logic [2:0] alu_of(input logic [5:0] op);
    case (op)
      B_SUB, B_BEQ, B_BNE:    return 3'b001;
      B_SLL:                  return 3'b010;
      B_ORI:                  return 3'b011;
      B_AND, B_ANDI:          return 3'b100;
      B_SLT, B_SLTI, B_BLTZ:  return 3'b110;
      default:                return 3'b000;
    endcase
  endfunction

  task automatic model(input logic [5:0] op, input int p, input logic z, input logic s,
                       output logic [19:0] exp, output logic [19:0] mask);
    kind_t k;
    int n;
    logic [2:0] st, alu;
    logic [1:0] pcsrc, dst;
    logic pcwre, irwre, regwre, mrd, mwr, wr, srca, srcb, ext, db;
    logic m_pcsrc, m_dst, m_sel, m_alu, m_db, tk;
    k = kind_of(op);
    n = n_phases(k);
    st = state_at(k, p);
    irwre = (st == 3'd0);
    pcwre = (k != K_HALT) && (p == n - 1);
    regwre = (k == K_JAL && st == 3'd1) ||
             (st == 3'd4 && (k == K_RTYPE || k == K_ITYPE || k == K_LW));
    mrd = (k == K_LW && st == 3'd3);
    mwr = (k == K_SW && st == 3'd3);
    tk = (op == B_BEQ && z) || (op == B_BNE && !z) || (op == B_BLTZ && s);
    pcsrc = 2'b00;
    if (st == 3'd1 && (k == K_J || k == K_JAL)) pcsrc = 2'b11;
    if (st == 3'd1 && k == K_JR) pcsrc = 2'b10;
    if (st == 3'd2 && k == K_BR && tk) pcsrc = 2'b01;
    m_pcsrc = pcwre || irwre;
    m_dst = 1'b0; dst = 2'b00; wr = 1'b0;
    if (k == K_JAL && st == 3'd1) begin
      m_dst = 1'b1; dst = 2'b00; wr = 1'b0;
    end else if (st == 3'd4 && regwre) begin
      m_dst = 1'b1; dst = (k == K_RTYPE) ? 2'b10 : 2'b01; wr = 1'b1;
    end
    m_sel = (st == 3'd2 || st == 3'd3 || st == 3'd4);
    m_alu = m_sel && (k != K_NOP);
    srca = (op == B_SLL);
    srcb = (op == B_ADDIU || op == B_ANDI || op == B_ORI || op == B_SLTI || op == B_LW || op == B_SW);
    ext  = (op == B_ADDIU || op == B_SLTI || op == B_LW || op == B_SW || k == K_BR);
    alu = alu_of(op);
    db = (k == K_LW);
    m_db = (st == 3'd4);
    exp  = {pcwre, pcsrc, irwre, regwre, dst, wr, srca, srcb, alu, ext, mrd, mwr, db, st};
    mask = {1'b1, {2{m_pcsrc}}, 1'b1, 1'b1, {2{m_dst}}, m_dst, m_sel, m_sel, {3{m_alu}},
            m_sel, 1'b1, 1'b1, m_db, 3'b111};
  endtask

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] want);
    compared++;
    assert (got === want) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, got, want);
    end
  endtask

  // Runs one instruction from a negedge with the DUT in IF; zs<0 randomizes zero/sign.
  task automatic apply_stimulus(input logic [5:0] op, input int zs, input int abort_at);
    kind_t k;
    int n;
    int pulses;
    logic [19:0] e, m;
    k = kind_of(op);
    n = n_phases(k);
    pulses = 0;
    opcode = op;
    for (int p = 0; p < n; p++) begin
      if (zs < 0) begin
        zero = 1'($urandom_range(0, 1));
        sign = 1'($urandom_range(0, 1));
      end else begin
        zero = zs[1];
        sign = zs[0];
      end
      #2;
      model(op, p, zero, sign, e, m);
      check_output($sformatf("op%b_p%0d", op, p), {12'd0, obs & m}, {12'd0, e & m});
      if (PCWre) pulses++;
      if (p == abort_at) begin
        #1 nReset = 1'b0;
        #1;
        check_output("abort_state",  32'(State),  32'd0);
        check_output("abort_regwre", 32'(RegWre), 32'd0);
        check_output("abort_pcwre",  32'(PCWre),  32'd0);
        check_output("abort_irwre",  32'(IRWre),  32'd1);
        @(negedge CLK);
        nReset = 1'b1;
        return;
      end
      @(negedge CLK);
    end
    if (k != K_HALT) check_output($sformatf("one_pcwre_op%b", op), 32'(pulses), 32'd1);
  endtask

  logic [5:0] listed [17] = '{B_ADD, B_SUB, B_ADDIU, B_AND, B_ANDI, B_ORI, B_SLL, B_SLT,
                             B_SLTI, B_SW, B_LW, B_BEQ, B_BNE, B_BLTZ, B_J, B_JR, B_JAL};

  initial begin
    logic [19:0] e, m;
    logic [5:0] op;
    nReset = 1'b0;
    opcode = B_ADD;
    zero = 1'b0;
    sign = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    #2;
    model(B_ADD, 0, 1'b0, 1'b0, e, m);
    check_output("reset_outputs", {12'd0, obs & m}, {12'd0, e & m});
    @(negedge CLK);
    nReset = 1'b1;

    apply_stimulus(B_ADD, -1, 3);
    apply_stimulus(B_ADD, -1, -1);
    apply_stimulus(B_LW, -1, -1);
    apply_stimulus(B_SW, -1, -1);
    apply_stimulus(B_BEQ, 2, -1);
    apply_stimulus(B_BEQ, 1, -1);
    apply_stimulus(B_BNE, 0, -1);
    apply_stimulus(B_BLTZ, 1, -1);
    apply_stimulus(B_BLTZ, 2, -1);
    apply_stimulus(B_JAL, -1, -1);
    apply_stimulus(B_JR, -1, -1);
    apply_stimulus(B_J, -1, -1);
    apply_stimulus(6'b000011, -1, -1);

    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        op = 6'b101010;
        for (int t = 0; t < 50; t++) begin
          op = 6'($urandom);
          if (kind_of(op) == K_NOP) break;
        end
        if (kind_of(op) != K_NOP) op = 6'b101010;
      end else begin
        op = listed[$urandom_range(0, 16)];
      end
      apply_stimulus(op, -1, -1);
    end

    apply_stimulus(B_HALT, -1, -1);
    #3 nReset = 1'b0;
    #1 check_output("halt_reset_state", 32'(State), 32'd0);
    @(negedge CLK);
    nReset = 1'b1;

`ifdef PERF_CNT_EN
    check_output("perf_cycle_clr", cycleCnt, 32'd0);
    check_output("perf_instr_clr", instrCnt, 32'd0);
    apply_stimulus(B_ADD, -1, -1);
    apply_stimulus(B_ADD, -1, -1);
    apply_stimulus(B_ADD, -1, -1);
    apply_stimulus(B_HALT, -1, -1);
    #2;
    check_output("perf_instr", instrCnt, 32'd3);
    check_output("perf_cycle", cycleCnt, 32'd14);
    repeat (5) @(negedge CLK);
    #2 check_output("perf_cycle_frozen", cycleCnt, 32'd14);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
